// File: rtl/adder_mul_sequencer.sv
// Shift-add unsigned multiplier controller that borrows the shared external adder:
// one conditional add per cycle over BITS cycles, then a one-cycle done pulse.
module adder_mul_sequencer #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [BITS-1:0] multiplicand,
  input  logic [BITS-1:0] multiplier,
  output logic [BITS-1:0] add_a,
  output logic [BITS-1:0] add_b,
  input  logic [BITS:0]   add_sum,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] product_hi,
  output logic [BITS-1:0] product_lo
);

  localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t            state;
  logic [BITS-1:0]   mc;
  logic [BITS-1:0]   hi;
  logic [BITS-1:0]   lo;
  logic [CNT_W-1:0]  cnt;

  // The adder's carry-out lands in hi[BITS-1] and its LSB becomes the next product
  // bit shifted into lo, so no bit of the partial product is ever lost.
  logic [BITS-1:0] hi_next;
  logic [BITS-1:0] lo_next;

  assign hi_next = add_sum[BITS:1];
  assign lo_next = {add_sum[0], lo[BITS-1:1]};

  assign product_hi = hi;
  assign product_lo = lo;

  // NOTE: every register here, outputs included, is assigned with <= so all of them
  // see pre-edge values; add_a/add_b are precomputed one edge early so they only
  // change on clock edges and present HI / (LO[0] ? MC : 0) during each iteration.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      mc    <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      add_a <= '0;
      add_b <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mc    <= multiplicand;
            hi    <= '0;
            lo    <= multiplier;
            cnt   <= '0;
            state <= ITER;
            busy  <= 1'b1;
            add_a <= '0;
            add_b <= multiplier[0] ? multiplicand : '0;
          end
        end

        ITER: begin
          hi  <= hi_next;
          lo  <= lo_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            add_a <= '0;
            add_b <= '0;
          end else begin
            add_a <= hi_next;
            add_b <= lo_next[0] ? mc : '0;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          add_a <= '0;
          add_b <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_mul_sequencer.sv
// Scoreboard bench for adder_mul_sequencer: a cycle-count reference model queues the
// expected product at each accepted start; a negedge monitor compares outputs.
module tb_adder_mul_sequencer;

  localparam int BITS = 32;
  localparam int PW   = 2 * BITS;

  logic            clk;
  logic            clr;
  logic            start;
  logic [BITS-1:0] multiplicand;
  logic [BITS-1:0] multiplier;
  logic [BITS-1:0] add_a;
  logic [BITS-1:0] add_b;
  logic [BITS:0]   add_sum;
  logic            busy;
  logic            done;
  logic [BITS-1:0] product_hi;
  logic [BITS-1:0] product_lo;

  adder_mul_sequencer #(.BITS(BITS)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_sum      (add_sum),
    .busy         (busy),
    .done         (done),
    .product_hi   (product_hi),
    .product_lo   (product_lo)
  );

  // The shared adder the sequencer borrows.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dut_dones = 0;

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    check(name, PW'(got), PW'(want));
  endtask

  always @(posedge clk) cyc++;

  // Reference model: cd counts cycles remaining in an operation (BITS+1 .. 2 busy,
  // 1 done, 0 idle); the product is plain arithmetic on the operands at acceptance.
  int              cd = 0;
  int              accepts = 0;
  logic [PW-1:0]   hold = '0;
  logic [BITS-1:0] m_mc = '0;
  logic [PW-1:0]   exp_q[$];
  int              done_times[$];

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      cd   = 0;
      hold = '0;
      m_mc = '0;
      exp_q.delete();
    end else if (cd > 0) begin
      cd--;
    end else if (start) begin
      cd   = BITS + 1;
      m_mc = multiplicand;
      hold = PW'(multiplicand) * PW'(multiplier);
      exp_q.push_back(hold);
      accepts++;
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on every done.
  always @(negedge clk) begin
    if (!clr) begin
      check_bit("busy", busy, (cd >= 2) && (cd <= BITS + 1));
      check_bit("done", done, cd == 1);
      check_bit("busy_done_excl", busy && done, 1'b0);
      if (cd == 0) begin
        check("product_hold", {product_hi, product_lo}, hold);
        check("idle_add_a", PW'(add_a), '0);
        check("idle_add_b", PW'(add_b), '0);
      end
      if (cd == BITS + 1) check("first_add_a", PW'(add_a), '0);
      if (cd >= 2) check_bit("add_b_src", (add_b == '0) || (add_b == m_mc), 1'b1);
      if (done) begin
        dut_dones++;
        done_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with empty scoreboard, want no done (cycle %0d)", cyc);
        end else begin
          check("product", {product_hi, product_lo}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && cd != 0; n++) tick();
  endtask

  task automatic mul(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    wait_idle();
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int n;
    clr          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    tick();
    tick();
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check("reset_add_a", PW'(add_a), '0);
    check("reset_add_b", PW'(add_b), '0);
    check("reset_product", {product_hi, product_lo}, '0);

    // Release reset and request the first multiply on the very first clean edge.
    clr          = 1'b0;
    multiplicand = 32'd6;
    multiplier   = 32'd7;
    start        = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
    check("mul_6x7", {product_hi, product_lo}, 64'h0000_0000_0000_002A);

    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul_max", {product_hi, product_lo}, 64'hFFFF_FFFE_0000_0001);

    mul(32'h0, 32'h1234_5678);
    check("mul_zero_a", {product_hi, product_lo}, 64'h0);
    mul(32'h1234_5678, 32'h0);
    check("mul_zero_b", {product_hi, product_lo}, 64'h0);

    // start held with operands churning through ITER and DONE: one result, 3*5.
    d0           = dut_dones;
    multiplicand = 32'd3;
    multiplier   = 32'd5;
    start        = 1'b1;
    tick();
    for (int c = 0; c < 100 && cd != 1; c++) begin
      multiplicand = $urandom;
      multiplier   = $urandom;
      tick();
    end
    start = 1'b0;
    wait_idle();
    check("held_start_result", {product_hi, product_lo}, 64'd15);
    check("held_start_dones", PW'(dut_dones - d0), PW'(1));

    // Abort in the 10th iteration cycle.
    d0           = dut_dones;
    multiplicand = 32'hABCD_1234;
    multiplier   = 32'h0F0F_0F0F;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    clr = 1'b1;
    #1;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_done", done, 1'b0);
    check("abort_add_a", PW'(add_a), '0);
    check("abort_add_b", PW'(add_b), '0);
    check("abort_product", {product_hi, product_lo}, '0);
    tick();
    tick();
    clr = 1'b0;
    mul(32'h0001_0000, 32'h0001_0000);
    check("post_abort", {product_hi, product_lo}, 64'h0000_0001_0000_0000);
    check("abort_dones", PW'(dut_dones - d0), PW'(1));

    // Back-to-back: start held, new operands after each acceptance.
    wait_idle();
    d0           = done_times.size();
    n            = 0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    start        = 1'b1;
    for (int c = 0; c < 300 && n < 4; c++) begin
      tick();
      if (cd == BITS + 1) begin
        n++;
        multiplicand = $urandom;
        multiplier   = $urandom;
      end
    end
    start = 1'b0;
    wait_idle();
    check("b2b_done_count", PW'(done_times.size() - d0), PW'(4));
    for (int i = d0 + 1; i < done_times.size(); i++)
      check("b2b_gap", PW'(done_times[i] - done_times[i-1]), PW'(BITS + 2));

    // Random operands with occasional corner values and idle gaps.
    for (int i = 0; i < 20; i++) begin
      logic [BITS-1:0] a;
      logic [BITS-1:0] b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = '1;
        1: b = 32'h8000_0000;
        2: a = 32'd1;
        default: ;
      endcase
      mul(a, b);
      repeat ($urandom_range(0, 3)) tick();
    end

    wait_idle();
    tick();
    check("scoreboard_empty", PW'(exp_q.size()), '0);
    check("accepts_vs_dones", PW'(dut_dones), PW'(accepts - 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_mul_sequencer.md
# adder_mul_sequencer

Multi-cycle unsigned shift-add multiplier controller that reuses the shared carry-lookahead adder instead of a dedicated array multiplier. It latches two BITS-wide operands on a start pulse and performs one conditional add per cycle through the external adder, over BITS iterations. It then presents a 2*BITS-wide product with a one-cycle done pulse. It sits between the ALU control unit (MUL opcode) and the adder instance, and drives the adder's operand inputs only while busy.

## Interface
- BITS, 32, operand width; the product is 2*BITS wide
- clk  in  1  clock; all state updates on the rising edge
- clr  in  1  reset, asynchronous and active-high
- start  in  1  request a multiply; sampled only in IDLE
- multiplicand  in  BITS  operand A, latched when start is accepted
- multiplier  in  BITS  operand B, latched when start is accepted
- add_a  out  BITS  to the adder's summand1 input
- add_b  out  BITS  to the adder's summand2 input
- add_sum  in  BITS+1  from the adder's outputSum (combinational, same cycle)
- busy  out  1  high during the BITS iteration cycles
- done  out  1  one-cycle pulse when the product is valid
- product_hi  out  BITS  upper half of the product
- product_lo  out  BITS  lower half of the product

## Operation
- Registers:
  - MC (BITS): latched multiplicand
  - HI (BITS): accumulator
  - LO (BITS): multiplier, shifting out as product bits shift in
  - CNT (log2(BITS) bits): iteration counter
  - state: IDLE, ITER, DONE
- IDLE: busy=0, done=0, add_a=add_b=0.
  - start=1 → MC←multiplicand, HI←0, LO←multiplier, CNT←0, state←ITER.
- ITER: busy=1.
  - add_a=HI; add_b = LO[0] ? MC : 0.
  - At the edge: HI←add_sum[BITS:1], LO←{add_sum[0], LO[BITS-1:1]}, CNT←CNT+1.
  - When CNT==BITS-1 at the edge → state←DONE.
- DONE: done=1, busy=0, add_a=add_b=0; next edge → IDLE.
- Width rule: the adder carry-out add_sum[BITS] is never dropped; it becomes HI[BITS-1] after the shift. No overflow is possible.
- product_hi=HI and product_lo=LO at all times. They are final from the DONE cycle and hold until the next accepted start.
- start is ignored in ITER and in DONE (no queuing). The requester must hold or re-assert start in IDLE.
- The operand inputs are ignored except on the accepting edge. Changing them mid-operation has no effect.
- Reset:
  - clr=1 at any time, including mid-ITER, forces state=IDLE, HI=LO=MC=0, CNT=0.
  - Resulting outputs: busy=0, done=0, add_a=add_b=0, product_hi=product_lo=0.
  - An operation in progress is discarded. No done pulse is issued for it.

## Timing
- Let edge E0 sample start=1 in IDLE.
  - busy=1 in cycles E0+1 through E0+BITS (exactly BITS cycles).
  - done=1 in cycle E0+BITS+1 only.
  - The earliest next accepted start is at edge E0+BITS+2. Throughput is one multiply per BITS+2 cycles.
- add_a/add_b change only on clock edges. The adder path (register→adder→register) must close within one clk period.
- done and busy are never high together. Exactly one done pulse is issued per accepted start that is not aborted by clr.
- clr deassertion has no minimum-latency requirement. The first start can be accepted on the first rising edge with clr=0.

## Test plan
- 6×7, BITS=32: start pulse → busy high 32 cycles → done at E0+33 with product_hi=0x00000000, product_lo=0x0000002A.
- 0xFFFFFFFF×0xFFFFFFFF → product_hi=0xFFFFFFFE, product_lo=0x00000001. This checks carry-out retention on every iteration.
- Zero operands: 0×0x12345678 and 0x12345678×0 → product 0 in both cases. In the first case add_b=0 every cycle, since MC=0.
- Ignored start: start held high and operands changed during ITER and DONE → exactly one done. The result is for the originally latched operands, e.g. 3×5=15.
- Abort: clr asserted at the 10th ITER cycle → all outputs 0 immediately (asynchronous), and no done follows. Then 0x10000×0x10000 completes with product_hi=0x00000001, product_lo=0.
- Back-to-back: start re-asserted continuously → done pulses spaced exactly 34 cycles apart. Each product matches its operands; the first product holds until the second start is accepted.
